// File: rtl/neuron_sched.sv
// neuron_sched: control sequencer for a dot-product neuron layer (x/w BRAM reads, MAC control, y writes).
// Optional cycle counter port cyc_cnt_o is enabled by defining NEURON_SCHED_PERF_EN.
module neuron_sched #(
    parameter int unsigned N_IN     = 784,
    parameter int unsigned N_OUT    = 10,
    parameter int unsigned X_ADDR_W = 10,
    parameter int unsigned W_ADDR_W = 13,
    parameter int unsigned Y_ADDR_W = 6,
    parameter int unsigned Y_STRIDE = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_i,
    input  logic                abort_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                x_buf_en,
    output logic [X_ADDR_W-1:0] x_buf_addr,
    output logic                w_buf_en,
    output logic [W_ADDR_W-1:0] w_buf_addr,
    output logic                mac_clr,
    output logic                mac_valid,
    output logic                mac_last,
    input  logic                mac_done,
    output logic                y_buf_en,
    output logic                y_buf_wr_en,
`ifdef NEURON_SCHED_PERF_EN
    output logic [Y_ADDR_W-1:0] y_buf_addr,
    output logic [31:0]         cyc_cnt_o
`else
    output logic [Y_ADDR_W-1:0] y_buf_addr
`endif
);

    localparam int unsigned N_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam logic [X_ADDR_W-1:0] LAST_I = X_ADDR_W'(N_IN - 1);
    localparam logic [N_W-1:0]      LAST_N = N_W'(N_OUT - 1);
    localparam logic [Y_ADDR_W-1:0] Y_STEP = Y_ADDR_W'(Y_STRIDE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT_ACC,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                r_state;
    logic [N_W-1:0]        r_n;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_x_en;
    logic                  r_w_en;
    logic [X_ADDR_W-1:0]   r_x_addr;
    logic [W_ADDR_W-1:0]   r_w_addr;
    logic                  r_mac_clr;
    logic                  r_mac_valid;
    logic                  r_mac_last;
    logic                  r_y_en;
    logic                  r_y_wr;
    logic [Y_ADDR_W-1:0]   r_y_addr;
    logic                  w_last_elem;

    // Final element of the current neuron is being read this cycle.
    assign w_last_elem = (r_state == S_FETCH) && (r_x_addr == LAST_I);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_n         <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_x_en      <= 1'b0;
            r_w_en      <= 1'b0;
            r_x_addr    <= '0;
            r_w_addr    <= '0;
            r_mac_clr   <= 1'b0;
            r_mac_valid <= 1'b0;
            r_mac_last  <= 1'b0;
            r_y_en      <= 1'b0;
            r_y_wr      <= 1'b0;
            r_y_addr    <= '0;
        end else begin
            // MAC strobes trail the read by one cycle to line up with BRAM dout.
            r_mac_valid <= r_x_en & ~abort_i;
            r_mac_last  <= w_last_elem & ~abort_i;
            if (abort_i) begin
                r_state   <= S_IDLE;
                r_n       <= '0;
                r_busy    <= 1'b0;
                r_done    <= 1'b0;
                r_x_en    <= 1'b0;
                r_w_en    <= 1'b0;
                r_x_addr  <= '0;
                r_w_addr  <= '0;
                r_mac_clr <= 1'b0;
                r_y_en    <= 1'b0;
                r_y_wr    <= 1'b0;
                r_y_addr  <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start_i) begin
                            r_state   <= S_FETCH;
                            r_n       <= '0;
                            r_busy    <= 1'b1;
                            r_x_en    <= 1'b1;
                            r_w_en    <= 1'b1;
                            r_x_addr  <= '0;
                            r_w_addr  <= '0;
                            r_mac_clr <= 1'b1;
                            r_y_addr  <= '0;
                        end
                    end
                    S_FETCH: begin
                        r_mac_clr <= 1'b0;
                        r_w_addr  <= r_w_addr + W_ADDR_W'(1);
                        if (r_x_addr == LAST_I) begin
                            r_state  <= S_WAIT_ACC;
                            r_x_en   <= 1'b0;
                            r_w_en   <= 1'b0;
                            r_x_addr <= '0;
                        end else begin
                            r_x_addr <= r_x_addr + X_ADDR_W'(1);
                        end
                    end
                    S_WAIT_ACC: begin
                        if (mac_done) begin
                            r_state <= S_WRITE;
                            r_y_en  <= 1'b1;
                            r_y_wr  <= 1'b1;
                        end
                    end
                    S_WRITE: begin
                        r_y_en <= 1'b0;
                        r_y_wr <= 1'b0;
                        if (r_n == LAST_N) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            // w address already sits at (n+1)*N_IN from the running counter.
                            r_state   <= S_FETCH;
                            r_n       <= r_n + N_W'(1);
                            r_y_addr  <= r_y_addr + Y_STEP;
                            r_x_en    <= 1'b1;
                            r_w_en    <= 1'b1;
                            r_mac_clr <= 1'b1;
                        end
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef NEURON_SCHED_PERF_EN
    logic [31:0] r_cyc_cnt;

    // Counts FETCH..WRITE cycles so the value shown during DONE covers the whole run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cyc_cnt <= '0;
        end else if ((r_state == S_IDLE) && start_i && !abort_i) begin
            r_cyc_cnt <= '0;
        end else if (((r_state == S_FETCH) || (r_state == S_WAIT_ACC) || (r_state == S_WRITE))
                     && (r_cyc_cnt != 32'hFFFF_FFFF)) begin
            r_cyc_cnt <= r_cyc_cnt + 32'd1;
        end
    end

    assign cyc_cnt_o = r_cyc_cnt;
`endif

    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign x_buf_en    = r_x_en;
    assign x_buf_addr  = r_x_addr;
    assign w_buf_en    = r_w_en;
    assign w_buf_addr  = r_w_addr;
    assign mac_clr     = r_mac_clr;
    assign mac_valid   = r_mac_valid;
    assign mac_last    = r_mac_last;
    assign y_buf_en    = r_y_en;
    assign y_buf_wr_en = r_y_wr;
    assign y_buf_addr  = r_y_addr;

endmodule
